tx_len_mux_streamer: RTL and testbench
======================================

// Module: tx_len_mux_streamer
// PURPOSE
//  Length-specified TX streamer, parametrised successor of the single-channel 32-bit streamer.
//  Receives a 5-byte command on a byte-wide AXI-stream slave: channel byte, then 32-bit length, LSB first.
//  Then forwards exactly <length> bytes from the selected clk-domain channel stream to a DW_BYTES-wide master.
//  Drives tkeep/tlast on the final beat. Sits between the host-command RX path and the USB FIFO TX path.
// PARAMETERS
//  DW_BYTES  4   output/source beat width in bytes (power of 2, >=4)
//  NCH       4   number of source channels (1..256)
//  CH_W      2   channel index width, $clog2(NCH) (min 1)
// PORTS
//  clk       in   1               single clock, all logic rising-edge
//  rstn      in   1               asynchronous active-low reset
//  i_tready  out  1               command slave ready
//  i_tvalid  in   1               command slave valid
//  i_tdata   in   8               command byte
//  s_tvalid  in   NCH             per-channel source valid
//  s_tready  out  NCH             per-channel source ready (one-hot or zero)
//  s_tdata   in   NCH*DW_BYTES*8  channel c occupies bits [c*DW_BYTES*8 +: DW_BYTES*8]
//  o_tready  in   1               master ready
//  o_tvalid  out  1               master valid
//  o_tdata   out  DW_BYTES*8      master data
//  o_tkeep   out  DW_BYTES        master byte enables
//  o_tlast   out  1               master last beat
//  busy      out  1               high in any state other than IDLE
//  err_badch out  1               1-cycle pulse when channel byte >= NCH
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, remaining=0, o_tvalid=0, o_tlast=0, o_tkeep=0, o_tdata=0, err_badch=0, s_tready=0.
//  Reset mid-command or mid-stream aborts it. Partial command bytes are discarded; no beat is emitted after reset.
//  States: IDLE -> CMD -> CHK -> [HDR] -> STREAM -> IDLE.
//   IDLE/CMD: i_tready=1. The byte counter 0..4 advances on each i_tvalid&&i_tready. Byte0 is the channel, bytes 1-4 are length[7:0]..[31:24].
//   CHK (1 cycle, i_tready=0):
//    - channel >= NCH: pulse err_badch, -> IDLE.
//    - length==0: -> IDLE, no output beat.
//    - otherwise: -> HDR (macro on) or STREAM.
//  Outside IDLE/CMD, i_tready=0.
//  STREAM: one output register. Load enable ld = s_tvalid[sel] && (~o_tvalid || o_tready) && remaining!=0.
//   s_tready[sel] = (~o_tvalid || o_tready) && remaining!=0. All other bits of s_tready are 0.
//   On ld: o_tdata<=source beat; o_tvalid<=1; o_tkeep<= remaining>=DW_BYTES ? all ones : (1<<remaining)-1;
//   o_tlast<=(remaining<=DW_BYTES); remaining<=remaining-min(remaining,DW_BYTES).
//   If o_tready is high and ld is not asserted, o_tvalid<=0.
//   When o_tvalid&&o_tready&&o_tlast: -> IDLE the same cycle. A new command is accepted the next cycle.
//  AXI rules: o_tvalid, once high, holds with stable o_tdata/o_tkeep/o_tlast until o_tready. Full throughput is 1 beat/cycle.
//  Latency: a source beat accepted in cycle N is presented on the master in cycle N+1.
//  Length arithmetic is 32-bit unsigned with no wrap. The final partial beat carries only the low bytes; the upper source bytes are discarded.
//  Byte order in a beat: byte0 = o_tdata[7:0].
//  Length 0xFFFFFFFF is legal and streams until done or reset.
// CONFIGURATION
//  TX_LEN_HDR_EN defined:
//   - HDR state emits one beat before the data: o_tdata={zero pad, channel byte at [39:32] if DW_BYTES>4 else dropped, length[31:0]}, o_tkeep all ones, o_tlast=0.
//   - HDR holds until o_tready, then -> STREAM. The header does not decrement remaining.
//  TX_LEN_HDR_EN undefined: HDR state and its logic are absent; CHK goes directly to STREAM.
// STRUCTURE
//  Package tx_len_pkg: state enum (IDLE,CMD,CHK,HDR,STREAM), CMD_BYTES=5, keep-mask function keep_for(remaining).
//  Sub-module tx_len_cmd_rx: byte collector for the 5-byte command. Outputs cmd_valid pulse, channel, length. Owns i_tready.
//  Top holds the FSM, channel mux, output register, remaining counter.
// TESTING
//  1 DW=4,NCH=4; cmd {ch=2,len=10}; ch2 supplies words 0x03020100,0x07060504,0x0B0A0908 -> 3 beats, keeps F,F,3; tlast on 3rd; s_tready[0,1,3]=0 throughout.
//  2 cmd {ch=5,len=8} with NCH=4 -> err_badch one pulse, no o_tvalid, i_tready high again 1 cycle later.
//  3 cmd {ch=0,len=0} -> no beat, busy drops after CHK, s_tready[0] never high.
//  4 len=16, o_tready toggled 1010..., s_tvalid random -> o_tdata stable while stalled, 4 beats in order, no loss/duplication.
//  5 rstn pulsed low after 2 of 4 output beats -> o_tvalid=0 immediately; new cmd {ch=1,len=4} -> one beat keep F tlast=1.
//  6 TX_LEN_HDR_EN, cmd {ch=1,len=5} -> header beat 0x00000005 keep F tlast 0, then data keeps F,1 with tlast on the last.

Source files
------------

// File: rtl/tx_len_pkg.sv
// Shared types and helpers for the length-specified TX streamer.
package tx_len_pkg;

    typedef enum logic [2:0] {IDLE, CMD, CHK, HDR, STREAM} state_t;

    localparam int CMD_BYTES = 5;
    localparam int KEEP_MAX  = 128;

    // Byte-enable mask for the next beat: the low min(remaining, dw_bytes) bits set.
    function automatic logic [KEEP_MAX-1:0] keep_for(input logic [31:0] remaining,
                                                     input int          dw_bytes);
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            k[i] = (i < dw_bytes) && (32'(i) < remaining);
        end
        return k;
    endfunction

endpackage

// File: rtl/tx_len_cmd_rx.sv
// Collects the 5-byte command (channel, then 32-bit length LSB first) from the byte stream.
module tx_len_cmd_rx
    import tx_len_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        i_tvalid,
    input  logic [7:0]  i_tdata,
    output logic        i_tready,
    output logic        cmd_valid,
    output logic [7:0]  channel,
    output logic [31:0] length
);

    logic [2:0] cnt;
    logic       acc;

    assign i_tready  = en;
    assign acc       = i_tvalid && en;
    // Combinational so the FSM leaves CMD before a sixth byte can be taken.
    assign cmd_valid = acc && (cnt == 3'(CMD_BYTES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            channel <= '0;
            length  <= '0;
        end else if (acc) begin
            case (cnt)
                3'd0:    channel        <= i_tdata;
                3'd1:    length[7:0]    <= i_tdata;
                3'd2:    length[15:8]   <= i_tdata;
                3'd3:    length[23:16]  <= i_tdata;
                default: length[31:24]  <= i_tdata;
            endcase
            cnt <= cmd_valid ? 3'd0 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/tx_len_mux_streamer.sv
// Length-specified multi-channel TX streamer. Optional header beat: define TX_LEN_HDR_EN.
//
// state  | meaning
// IDLE   | waiting for the first command byte
// CMD    | collecting the remaining command bytes
// CHK    | one cycle: validate channel and length
// HDR    | header beat presented, waiting for o_tready (TX_LEN_HDR_EN only)
// STREAM | forwarding source beats until the tlast beat is taken
module tx_len_mux_streamer
    import tx_len_pkg::*;
#(
    parameter int DW_BYTES = 4,
    parameter int NCH      = 4,
    parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    output logic                      i_tready,
    input  logic                      i_tvalid,
    input  logic [7:0]                i_tdata,
    input  logic [NCH-1:0]            s_tvalid,
    output logic [NCH-1:0]            s_tready,
    input  logic [NCH*DW_BYTES*8-1:0] s_tdata,
    input  logic                      o_tready,
    output logic                      o_tvalid,
    output logic [DW_BYTES*8-1:0]     o_tdata,
    output logic [DW_BYTES-1:0]       o_tkeep,
    output logic                      o_tlast,
    output logic                      busy,
    output logic                      err_badch
);

    localparam int DW = DW_BYTES * 8;

    state_t          state, state_nx;
    logic [31:0]     remaining, dec;
    logic [7:0]      ch;
    logic [31:0]     cmd_len;
    logic            cmd_valid, rx_en, rx_acc;
    logic            bad_ch, cmd_go;
    logic [CH_W-1:0] sel;
    logic            src_valid;
    logic [DW-1:0]   src_data, data_m;
    logic [DW_BYTES-1:0] keep;
    logic            can_take, ld;

    tx_len_cmd_rx u_cmd_rx (
        .clk       (clk),
        .rstn      (rstn),
        .en        (rx_en),
        .i_tvalid  (i_tvalid),
        .i_tdata   (i_tdata),
        .i_tready  (i_tready),
        .cmd_valid (cmd_valid),
        .channel   (ch),
        .length    (cmd_len)
    );

    assign rx_en     = (state == IDLE) || (state == CMD);
    assign rx_acc    = i_tvalid && i_tready;
    assign bad_ch    = {1'b0, ch} >= 9'(NCH);
    assign cmd_go    = !bad_ch && (cmd_len != 32'd0);
    assign err_badch = (state == CHK) && bad_ch;
    assign busy      = (state != IDLE);
    assign sel       = ch[CH_W-1:0];

    always_comb begin
        src_valid = 1'b0;
        src_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel == CH_W'(c)) begin
                src_valid = s_tvalid[c];
                src_data  = s_tdata[c*DW +: DW];
            end
        end
    end

    assign can_take = (state == STREAM) && (!o_tvalid || o_tready) && (remaining != 32'd0);
    assign ld       = can_take && src_valid;
    assign s_tready = can_take ? (NCH'(1) << sel) : '0;
    assign keep     = DW_BYTES'(keep_for(remaining, DW_BYTES));
    assign dec      = (remaining >= 32'(DW_BYTES)) ? 32'(DW_BYTES) : remaining;

    // Bytes beyond the remaining length are zeroed on the final partial beat.
    always_comb begin
        data_m = '0;
        for (int b = 0; b < DW_BYTES; b++) begin
            data_m[b*8 +: 8] = keep[b] ? src_data[b*8 +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (rx_acc) state_nx = CMD;
            CMD:    if (cmd_valid) state_nx = CHK;
            CHK: begin
                if (!cmd_go) begin
                    state_nx = IDLE;
                end else begin
`ifdef TX_LEN_HDR_EN
                    state_nx = HDR;
`else
                    state_nx = STREAM;
`endif
                end
            end
`ifdef TX_LEN_HDR_EN
            HDR:    if (o_tready) state_nx = STREAM;
`endif
            STREAM: if (o_tvalid && o_tready && o_tlast) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state <= state_nx;
            if (state == CHK && cmd_go) begin
                remaining <= cmd_len;
            end else if (ld) begin
                remaining <= remaining - dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tkeep  <= '0;
            o_tlast  <= 1'b0;
        end else if (ld) begin
            o_tvalid <= 1'b1;
            o_tdata  <= data_m;
            o_tkeep  <= keep;
            o_tlast  <= (remaining <= 32'(DW_BYTES));
        end
`ifdef TX_LEN_HDR_EN
        else if (state == CHK && cmd_go) begin
            // Channel lands at [39:32] only when the beat is wide enough; truncated otherwise.
            o_tvalid <= 1'b1;
            o_tdata  <= DW'({ch, cmd_len});
            o_tkeep  <= '1;
            o_tlast  <= 1'b0;
        end
`endif
        else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx_len_mux_streamer.sv
// Directed bench for tx_len_mux_streamer (DW_BYTES=4, NCH=4); header case under TX_LEN_HDR_EN.
module tb_tx_len_mux_streamer;

    localparam int DW_BYTES = 4;
    localparam int NCH      = 4;
    localparam int CH_W     = 2;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      i_tready;
    logic                      i_tvalid;
    logic [7:0]                i_tdata;
    logic [NCH-1:0]            s_tvalid;
    logic [NCH-1:0]            s_tready;
    logic [NCH*DW_BYTES*8-1:0] s_tdata;
    logic                      o_tready;
    logic                      o_tvalid;
    logic [DW_BYTES*8-1:0]     o_tdata;
    logic [DW_BYTES-1:0]       o_tkeep;
    logic                      o_tlast;
    logic                      busy;
    logic                      err_badch;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_data [8];
    logic [3:0]  got_keep [8];
    logic        got_last [8];
    int          got_n;
    int          stall_err;
    int          other_rdy;

    tx_len_mux_streamer #(.DW_BYTES(DW_BYTES), .NCH(NCH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_tready  (i_tready),
        .i_tvalid  (i_tvalid),
        .i_tdata   (i_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .o_tready  (o_tready),
        .o_tvalid  (o_tvalid),
        .o_tdata   (o_tdata),
        .o_tkeep   (o_tkeep),
        .o_tlast   (o_tlast),
        .busy      (busy),
        .err_badch (err_badch)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   w;
        logic rdy;
        i_tvalid = 1'b1;
        i_tdata  = b;
        w = 0;
        do begin
            #1;
            rdy = i_tready;
            @(posedge clk);
            #1;
            w++;
        end while (!rdy && w < 20);
        i_tvalid = 1'b0;
        total++;
        if (rdy !== 1'b1) begin
            bad++;
            $display("FAIL cmd_byte_accept: i_tready=%0b required 1 within 20 cycles", rdy);
        end
    endtask

    task automatic send_cmd(input logic [7:0] ch, input logic [31:0] len);
        send_byte(ch);
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    endtask

    // Drives source/master for up to 300 cycles, recording master handshakes until exp_n beats.
    task automatic stream_run(input int ch, input int exp_n, input bit toggle, input bit rnd);
        int          widx, cyc;
        logic        phase, held_v, held_l;
        logic [31:0] held_d;
        logic [3:0]  held_k;
        got_n = 0; stall_err = 0; other_rdy = 0;
        widx = 0; cyc = 0; phase = 1'b1; held_v = 1'b0;
        held_d = '0; held_k = '0; held_l = 1'b0;
        while (got_n < exp_n && cyc < 300) begin
            for (int c = 0; c < NCH; c++) s_tdata[c*32 +: 32] = 32'hDEAD0000 | 32'(c);
            s_tvalid = '1;
            s_tdata[ch*32 +: 32] = 32'h03020100 + 32'(widx) * 32'h04040404;
            s_tvalid[ch] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            o_tready = toggle ? phase : 1'b1;
            #1;
            if (held_v && (!o_tvalid || o_tdata !== held_d || o_tkeep !== held_k || o_tlast !== held_l))
                stall_err++;
            if ((s_tready & ~(4'(1) << ch)) != 0) other_rdy++;
            if (s_tvalid[ch] && s_tready[ch]) widx++;
            if (o_tvalid && o_tready) begin
                if (got_n < 8) begin
                    got_data[got_n] = o_tdata;
                    got_keep[got_n] = o_tkeep;
                    got_last[got_n] = o_tlast;
                end
                got_n++;
            end
            held_v = o_tvalid && !o_tready;
            held_d = o_tdata; held_k = o_tkeep; held_l = o_tlast;
            phase = !phase;
            @(posedge clk);
            #1;
            cyc++;
        end
        s_tvalid = '0;
        o_tready = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        i_tvalid = 1'b0; i_tdata = '0;
        s_tvalid = '0; s_tdata = '0; o_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_tvalid, o_tlast, o_tkeep, err_badch, busy} !== 8'b0 || o_tdata !== 32'h0 || s_tready !== 4'h0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0b last=%0b keep=%h data=%h err=%0b busy=%0b s_tready=%h required all 0",
                     o_tvalid, o_tlast, o_tkeep, o_tdata, err_badch, busy, s_tready);
        end
        rstn = 1'b1;
        tick();
        total++;
        if (i_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_i_tready: got %0b required 1", i_tready);
        end
    endtask

    task automatic test_basic;
        logic [31:0] exp_d [3];
        logic [3:0]  exp_k [3];
        logic        exp_l [3];
        exp_d[0] = 32'h03020100; exp_k[0] = 4'hF; exp_l[0] = 1'b0;
        exp_d[1] = 32'h07060504; exp_k[1] = 4'hF; exp_l[1] = 1'b0;
        exp_d[2] = 32'h00000908; exp_k[2] = 4'h3; exp_l[2] = 1'b1;
        send_cmd(8'd2, 32'd10);
        stream_run(2, 3, 1'b0, 1'b0);
        total++;
        if (got_n != 3) begin
            bad++;
            $display("FAIL basic_beats: got %0d required 3", got_n);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_data[i] !== exp_d[i] || got_keep[i] !== exp_k[i] || got_last[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL basic_beat%0d: data=%h keep=%h last=%0b required data=%h keep=%h last=%0b",
                         i, got_data[i], got_keep[i], got_last[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        total++;
        if (other_rdy != 0) begin
            bad++;
            $display("FAIL basic_other_s_tready: %0d cycles high required 0", other_rdy);
        end
        total++;
        if (busy !== 1'b0 || i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL basic_return_idle: busy=%0b i_tready=%0b o_tvalid=%0b required 0,1,0", busy, i_tready, o_tvalid);
        end
    endtask

    task automatic test_bad_channel;
        int n;
        send_cmd(8'd5, 32'd8);
        total++;
        if (err_badch !== 1'b1 || i_tready !== 1'b0) begin
            bad++;
            $display("FAIL badch_chk: err_badch=%0b i_tready=%0b required 1,0", err_badch, i_tready);
        end
        tick();
        total++;
        if (err_badch !== 1'b0 || i_tready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL badch_after: err_badch=%0b i_tready=%0b busy=%0b required 0,1,0", err_badch, i_tready, busy);
        end
        n = 0;
        s_tvalid = '1; o_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (o_tvalid || err_badch || s_tready != 0) n++;
            tick();
        end
        s_tvalid = '0;
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL badch_quiet: %0d active cycles required 0", n);
        end
    endtask

    task automatic test_zero_len;
        int n;
        send_cmd(8'd0, 32'd0);
        total++;
        if (busy !== 1'b1 || err_badch !== 1'b0) begin
            bad++;
            $display("FAIL zero_chk: busy=%0b err_badch=%0b required 1,0", busy, err_badch);
        end
        s_tvalid = '1; o_tready = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_busy: got %0b required 0", busy);
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_tvalid || s_tready[0]) n++;
            tick();
        end
        s_tvalid = '0;
        total++;
        if (n != 0) begin
            bad++;
            $display("FAIL zero_no_beat: %0d active cycles required 0", n);
        end
    endtask

    task automatic test_backpressure;
        send_cmd(8'd3, 32'd16);
        stream_run(3, 4, 1'b1, 1'b1);
        total++;
        if (got_n != 4) begin
            bad++;
            $display("FAIL bp_beats: got %0d required 4", got_n);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_data[i] !== 32'h03020100 + 32'(i) * 32'h04040404 || got_keep[i] !== 4'hF ||
                got_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL bp_beat%0d: data=%h keep=%h last=%0b required data=%h keep=f last=%0b",
                         i, got_data[i], got_keep[i], got_last[i],
                         32'h03020100 + 32'(i) * 32'h04040404, (i == 3));
            end
        end
        total++;
        if (stall_err != 0 || other_rdy != 0) begin
            bad++;
            $display("FAIL bp_stable: stall_err=%0d other_rdy=%0d required 0,0", stall_err, other_rdy);
        end
    endtask

    task automatic test_reset_abort;
        send_cmd(8'd1, 32'd16);
        stream_run(1, 2, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        total++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'h0) begin
            bad++;
            $display("FAIL abort_reset: o_tvalid=%0b busy=%0b s_tready=%h required 0,0,0", o_tvalid, busy, s_tready);
        end
        tick();
        rstn = 1'b1;
        tick();
        send_cmd(8'd1, 32'd4);
        stream_run(1, 1, 1'b0, 1'b0);
        total++;
        if (got_n != 1 || got_data[0] !== 32'h03020100 || got_keep[0] !== 4'hF || got_last[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_new_cmd: n=%0d data=%h keep=%h last=%0b required 1,03020100,f,1",
                     got_n, got_data[0], got_keep[0], got_last[0]);
        end
        repeat (3) begin
            total++;
            if (o_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL abort_extra_beat: o_tvalid=%0b required 0", o_tvalid);
            end
            tick();
        end
    endtask

`ifdef TX_LEN_HDR_EN
    task automatic test_header;
        logic [31:0] exp_d [3];
        logic [3:0]  exp_k [3];
        logic        exp_l [3];
        exp_d[0] = 32'h00000005; exp_k[0] = 4'hF; exp_l[0] = 1'b0;
        exp_d[1] = 32'h03020100; exp_k[1] = 4'hF; exp_l[1] = 1'b0;
        exp_d[2] = 32'h00000004; exp_k[2] = 4'h1; exp_l[2] = 1'b1;
        send_cmd(8'd1, 32'd5);
        stream_run(1, 3, 1'b0, 1'b0);
        total++;
        if (got_n != 3) begin
            bad++;
            $display("FAIL hdr_beats: got %0d required 3", got_n);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_data[i] !== exp_d[i] || got_keep[i] !== exp_k[i] || got_last[i] !== exp_l[i]) begin
                bad++;
                $display("FAIL hdr_beat%0d: data=%h keep=%h last=%0b required data=%h keep=%h last=%0b",
                         i, got_data[i], got_keep[i], got_last[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_channel();
        test_zero_len();
        test_backpressure();
        test_reset_abort();
`ifdef TX_LEN_HDR_EN
        test_header();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
